// File: rtl/stall_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// Stage and requester indices, flush FSM states and default depths.
package stall_pkg;

  localparam int PC    = 0;
  localparam int IFID  = 1;
  localparam int IDEX  = 2;
  localparam int EXMEM = 3;
  localparam int MEMWB = 4;

  localparam int REQ_IF  = 0;
  localparam int REQ_ID  = 1;
  localparam int REQ_MEM = 2;

  localparam int DEF_NREQ = 3;
  localparam logic [4*DEF_NREQ-1:0] DEF_REQ_DEPTH =
    {4'd5, 4'd3, 4'd2};

  typedef enum logic {
    F_IDLE,
    F_PEND
  } flush_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable, synchronous clear and async reset.
// Stops at MAX instead of wrapping.
module sat_counter #(
  parameter int         W   = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && q != MAX) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: freeze vector, held redirect flush,
// per-requester stall counters and a sticky stall watchdog.
module stall_flush_ctrl
  import stall_pkg::*;
#(
  parameter int              STAGES      = 6,
  parameter int              NREQ        = 3,
  parameter logic [4*NREQ-1:0] REQ_DEPTH = DEF_REQ_DEPTH,
  parameter int              FLUSH_STAGE = EXMEM,
  parameter int              CNT_W       = 32,
  parameter int              WDOG_LIMIT  = 1024
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [NREQ-1:0]       stall_req_i,
  input  logic                  flush_req_i,
  input  logic [31:0]           flush_pc_i,
  output logic [STAGES-1:0]     stall_o,
  output logic                  flush_o,
  output logic [31:0]           flush_pc_o,
  output logic [NREQ*CNT_W-1:0] stall_cnt_o,
  output logic                  wdog_o
);

  localparam int CW = $clog2(WDOG_LIMIT + 1);

  function automatic logic [STAGES-1:0] req_mask(
    input logic [3:0] d
  );
    logic [STAGES:0] m;
    m = ((STAGES+1)'(1) << d) - (STAGES+1)'(1);
    return m[STAGES-1:0];
  endfunction

  always_comb begin
    stall_o = '0;
    if (rst_in) begin
      stall_o = '0;
    end else if (!rdy_in) begin
      stall_o = '1;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (stall_req_i[i]) begin
          stall_o |= req_mask(REQ_DEPTH[4*i +: 4]);
        end
      end
    end
  end

  logic blocked;
  assign blocked = stall_o[FLUSH_STAGE];

  flush_state_t state_q, state_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  fpc_q, fpc_d;
  logic         flush_q, flush_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= F_IDLE;
      pend_q  <= '0;
      fpc_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      fpc_q   <= fpc_d;
      flush_q <= flush_d;
    end
  end

  // A paused CPU keeps every register, the kill pulse included.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    fpc_d   = fpc_q;
    flush_d = flush_q;
    if (rdy_in) begin
      flush_d = 1'b0;
      unique case (state_q)
        F_IDLE: begin
          if (flush_req_i) begin
            if (blocked) begin
              pend_d  = flush_pc_i;
              state_d = F_PEND;
            end else begin
              flush_d = 1'b1;
              fpc_d   = flush_pc_i;
            end
          end
        end
        F_PEND: begin
          if (blocked) begin
            if (flush_req_i) pend_d = flush_pc_i;
          end else begin
            flush_d = 1'b1;
            fpc_d   = flush_req_i ? flush_pc_i : pend_q;
            state_d = F_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign flush_o    = flush_q;
  assign flush_pc_o = fpc_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk(clk_in),
      .rst(rst_in),
      .en (rdy_in & stall_req_i[g]),
      .clr(1'b0),
      .q  (stall_cnt_o[g*CNT_W +: CNT_W])
    );
  end

  logic          any_req;
  logic [CW-1:0] consec;
  logic          wdog_q;

  assign any_req = |stall_req_i;

  sat_counter #(
    .W  (CW),
    .MAX(CW'(WDOG_LIMIT))
  ) u_consec (
    .clk(clk_in),
    .rst(rst_in),
    .en (rdy_in & any_req),
    .clr(rdy_in & ~any_req),
    .q  (consec)
  );

  // Trip on the same edge that carries consec up to the limit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wdog_q <= 1'b0;
    end else if (rdy_in && any_req &&
                 consec == CW'(WDOG_LIMIT - 1)) begin
      wdog_q <= 1'b1;
    end
  end

  assign wdog_o = wdog_q;

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Self-checking bench for stall_flush_ctrl: directed steps then
// random traffic against a behavioural reference model.
module tb_stall_flush_ctrl;

  localparam int CW = 4;
  localparam int WL = 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic [2:0]    stall_req_i;
  logic          flush_req_i;
  logic [31:0]   flush_pc_i;
  logic [5:0]    stall_o;
  logic          flush_o;
  logic [31:0]   flush_pc_o;
  logic [3*CW-1:0] stall_cnt_o;
  logic          wdog_o;

  stall_flush_ctrl #(
    .STAGES     (6),
    .NREQ       (3),
    .REQ_DEPTH  ({4'd5, 4'd3, 4'd2}),
    .FLUSH_STAGE(3),
    .CNT_W      (CW),
    .WDOG_LIMIT (WL)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .stall_req_i(stall_req_i),
    .flush_req_i(flush_req_i),
    .flush_pc_i (flush_pc_i),
    .stall_o    (stall_o),
    .flush_o    (flush_o),
    .flush_pc_o (flush_pc_o),
    .stall_cnt_o(stall_cnt_o),
    .wdog_o     (wdog_o)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  int depth [3] = '{2, 3, 5};

  bit          m_pend;
  logic [31:0] m_ppc;
  logic [31:0] m_fpc;
  bit          m_flush;
  int          m_cnt [3];
  int          m_consec;
  bit          m_wdog;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_stall(bit rdy,
                                           logic [2:0] req);
    int dmax;
    dmax = 0;
    if (!rdy) return 6'h3f;
    for (int i = 0; i < 3; i++)
      if (req[i] && depth[i] > dmax) dmax = depth[i];
    return 6'((1 << dmax) - 1);
  endfunction

  task automatic model_reset();
    m_pend   = 0;
    m_ppc    = 0;
    m_fpc    = 0;
    m_flush  = 0;
    m_consec = 0;
    m_wdog   = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic check_regs(string tag);
    chk({tag, ".flush_o"}, 64'(flush_o), 64'(m_flush));
    if (m_flush)
      chk({tag, ".flush_pc_o"}, 64'(flush_pc_o), 64'(m_fpc));
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s.cnt%0d", tag, i),
          64'(stall_cnt_o[i*CW +: CW]), 64'(m_cnt[i]));
    chk({tag, ".wdog_o"}, 64'(wdog_o), 64'(m_wdog));
  endtask

  task automatic cycle(string tag, bit rdy, logic [2:0] req,
                       bit fr, logic [31:0] pc);
    logic [5:0] es;
    bit blk;
    rdy_in      = rdy;
    stall_req_i = req;
    flush_req_i = fr;
    flush_pc_i  = pc;
    #1;
    es  = exp_stall(rdy, req);
    blk = es[3];
    chk({tag, ".stall_o"}, 64'(stall_o), 64'(es));
    if (rdy) begin
      m_flush = 0;
      if (!m_pend) begin
        if (fr && !blk) begin
          m_flush = 1;
          m_fpc   = pc;
        end else if (fr) begin
          m_pend = 1;
          m_ppc  = pc;
        end
      end else if (blk) begin
        if (fr) m_ppc = pc;
      end else begin
        m_flush = 1;
        m_fpc   = fr ? pc : m_ppc;
        m_pend  = 0;
      end
      for (int i = 0; i < 3; i++)
        if (req[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
      if (req != 0) begin
        if (m_consec < WL) m_consec++;
        if (m_consec == WL) m_wdog = 1;
      end else begin
        m_consec = 0;
      end
    end
    @(posedge clk_in);
    #1;
    check_regs(tag);
    @(negedge clk_in);
  endtask

  task automatic do_reset(string tag);
    rst_in = 1'b1;
    #1;
    chk({tag, ".rst.stall_o"}, 64'(stall_o), 64'd0);
    chk({tag, ".rst.flush_o"}, 64'(flush_o), 64'd0);
    chk({tag, ".rst.flush_pc_o"}, 64'(flush_pc_o), 64'd0);
    chk({tag, ".rst.cnt"}, 64'(stall_cnt_o), 64'd0);
    chk({tag, ".rst.wdog_o"}, 64'(wdog_o), 64'd0);
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in      = 1'b1;
    rdy_in      = 1'b1;
    stall_req_i = '0;
    flush_req_i = 1'b0;
    flush_pc_i  = '0;
    model_reset();
    @(negedge clk_in);
    do_reset("init");

    // stall priority
    cycle("prio011", 1, 3'b011, 0, 0);
    chk("prio011.const", 64'(stall_o), 64'b000111);
    cycle("prio101", 1, 3'b101, 0, 0);
    chk("prio101.const", 64'(stall_o), 64'b011111);
    cycle("prio000", 1, 3'b000, 0, 0);
    chk("prio000.const", 64'(stall_o), 64'b000000);

    // unblocked flush, then back-to-back pulses
    cycle("uflush", 1, 3'b010, 1, 32'h1000);
    chk("uflush.pulse", 64'(flush_o), 64'd1);
    chk("uflush.pc", 64'(flush_pc_o), 64'h1000);
    cycle("uflush_b2b", 1, 3'b000, 1, 32'h1100);
    cycle("uflush_end", 1, 3'b000, 0, 0);
    chk("uflush.one", 64'(flush_o), 64'd0);

    // pending flush, last pc wins
    cycle("pend0", 1, 3'b100, 1, 32'h2000);
    cycle("pend1", 1, 3'b100, 0, 0);
    cycle("pend2", 1, 3'b100, 1, 32'h3000);
    cycle("pend3", 1, 3'b100, 0, 0);
    cycle("pend4", 1, 3'b100, 0, 0);
    chk("pend.held", 64'(flush_o), 64'd0);
    cycle("pend5", 1, 3'b000, 0, 0);
    chk("pend.pulse", 64'(flush_o), 64'd1);
    chk("pend.pc", 64'(flush_pc_o), 64'h3000);
    cycle("pend6", 1, 3'b000, 0, 0);
    cycle("pend7", 1, 3'b000, 0, 0);

    // counter saturation
    do_reset("sat");
    for (int i = 0; i < 20; i++)
      cycle("sat", 1, 3'b001, 0, 0);
    chk("sat.f0", 64'(stall_cnt_o[3:0]), 64'd15);
    chk("sat.f12", 64'(stall_cnt_o[11:4]), 64'd0);

    // watchdog
    do_reset("wd");
    for (int i = 0; i < 7; i++) cycle("wd_a", 1, 3'b001, 0, 0);
    cycle("wd_idle", 1, 3'b000, 0, 0);
    for (int i = 0; i < 7; i++) cycle("wd_b", 1, 3'b010, 0, 0);
    chk("wd.before", 64'(wdog_o), 64'd0);
    cycle("wd_b8", 1, 3'b010, 0, 0);
    chk("wd.trip", 64'(wdog_o), 64'd1);
    for (int i = 0; i < 3; i++) cycle("wd_hold", 1, 3'b000, 0, 0);
    chk("wd.sticky", 64'(wdog_o), 64'd1);
    do_reset("wd_clr");

    // rdy_in low during MEM stall, flush ignored
    cycle("rdy_a", 1, 3'b100, 0, 0);
    cycle("rdy_b", 1, 3'b100, 0, 0);
    for (int i = 0; i < 3; i++)
      cycle("rdy_lo", 0, 3'b100, 1, 32'h5000);
    chk("rdy.cnt2", 64'(stall_cnt_o[11:8]), 64'd2);
    cycle("rdy_c", 1, 3'b000, 0, 0);
    chk("rdy.noflush", 64'(flush_o), 64'd0);

    // reset mid-PEND
    cycle("rp_a", 1, 3'b100, 1, 32'h4000);
    do_reset("rp");
    cycle("rp_b", 1, 3'b000, 0, 0);
    cycle("rp_c", 1, 3'b000, 0, 0);

    // reset while flush_o is high
    cycle("rf_a", 1, 3'b000, 1, 32'h6000);
    chk("rf.pulse", 64'(flush_o), 64'd1);
    do_reset("rf");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      bit          r;
      logic [2:0]  q;
      bit          f;
      logic [31:0] p;
      r = ($urandom_range(0, 9) != 0);
      q = ($urandom_range(0, 9) < 4) ? 3'b000
                                     : 3'($urandom_range(0, 7));
      f = ($urandom_range(0, 3) == 0);
      p = $urandom;
      if ($urandom_range(0, 99) == 0) do_reset("rnd");
      else cycle("rnd", r, q, f, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
